fetch_stage: RTL and testbench

- Instruction-fetch stage of the LEGv8 pipeline. Sits directly upstream of decode, where the sign extender consumes id_instr.
- Owns the PC and drives a single-outstanding-request instruction-memory port.
- Holds one fetched instruction in an IF/ID slot with a valid/ready handshake toward decode.
- Accepts a branch redirect (target = PC + scaled immediate from decode/execute), which flushes the wrong path.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 37 +++
 rtl/pc_reg.sv | 38 +++
 rtl/fetch_stage.sv | 157 +++++++++++++++
 tb/tb_fetch_stage.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int INSTR_W = 32;
    localparam int PC_INCR = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and IF/ID handshake.
interface fetch_stage_if
    import fetch_pkg::*;
#(
    parameter int PC_W = 64
) ();

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;

    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;

    logic               id_ready;
    logic               id_valid;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc;

    modport stage (
        output imem_req, imem_addr,
        input  imem_valid, imem_rdata,
        input  redirect_valid, redirect_pc,
        input  id_ready,
        output id_valid, id_instr, id_pc
    );

    modport env (
        input  imem_req, imem_addr,
        output imem_valid, imem_rdata,
        output redirect_valid, redirect_pc,
        output id_ready,
        input  id_valid, id_instr, id_pc
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter register: load beats increment beats hold.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC[PC_W-1:0]
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [PC_W-1:0] load_pc,
    input  logic            incr,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (incr) begin
            pc_d = pc_q + PC_W'(PC_INCR);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: owns the PC, one outstanding imem request, one IF/ID slot.
// Optional performance counters are enabled by defining ARKI_FETCH_PERF_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC[PC_W-1:0]
) (
    input  logic        clk,
    input  logic        reset,
`ifdef ARKI_FETCH_PERF_EN
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt,
`endif
    fetch_stage_if.stage bus
);

    fetch_state_t       state_q, state_d;
    logic               id_valid_q, id_valid_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [PC_W-1:0]    id_pc_q, id_pc_d;
    logic [PC_W-1:0]    drain_addr_q, drain_addr_d;

    logic [PC_W-1:0]    pc;
    logic               pc_incr;
    logic [PC_W-1:0]    redirect_target;
    logic               slot_free;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               mem_xfer;
    logic               dec_xfer;

    assign redirect_target = bus.redirect_pc & ~PC_W'(3);

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (bus.redirect_valid),
        .load_pc (redirect_target),
        .incr    (pc_incr),
        .pc      (pc)
    );

    // imem_req follows id_ready combinationally so a drained slot refills without a bubble.
    always_comb begin
        slot_free = !id_valid_q || bus.id_ready;
        imem_req  = ((state_q == FETCH) && slot_free) || (state_q == DRAIN);
        imem_addr = (state_q == DRAIN) ? drain_addr_q : pc;
        mem_xfer  = imem_req && bus.imem_valid;
        dec_xfer  = id_valid_q && bus.id_ready;
    end

    always_comb begin
        state_d      = state_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        drain_addr_d = drain_addr_q;
        pc_incr      = 1'b0;

        if (bus.redirect_valid) begin
            // A request still in flight must be swallowed before fetching the new path.
            id_valid_d   = 1'b0;
            drain_addr_d = imem_addr;
            state_d      = (imem_req && !bus.imem_valid) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                BOOT: begin
                    state_d = FETCH;
                end
                FETCH: begin
                    if (mem_xfer) begin
                        id_valid_d = 1'b1;
                        id_instr_d = bus.imem_rdata;
                        id_pc_d    = pc;
                        pc_incr    = 1'b1;
                    end else if (dec_xfer) begin
                        id_valid_d = 1'b0;
                    end
                end
                DRAIN: begin
                    if (mem_xfer) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            id_valid_q   <= 1'b0;
            id_instr_q   <= '0;
            id_pc_q      <= '0;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign bus.imem_req  = imem_req;
    assign bus.imem_addr = imem_addr;
    assign bus.id_valid  = id_valid_q;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc     = id_pc_q;

`ifdef ARKI_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Flushed instructions and redirect cycles are not counted as transfers or stalls.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (dec_xfer && !bus.redirect_valid && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (id_valid_q && !bus.id_ready && !bus.redirect_valid && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (bus.redirect_valid && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a perf sequence and random traffic vs a queue model.
module tb_fetch_stage;

    logic clk;
    logic rst_n;

    fetch_stage_if #(.PC_W(64)) bus ();

`ifdef ARKI_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    fetch_stage #(
        .PC_W     (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
`ifdef ARKI_FETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return 32'hB4000001 + (lo << 8);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst;
        bit          rdy;
        bit          rv;
        logic [63:0] rpc;
        bit          mv;
        bit          e_req;
        logic [63:0] e_addr;
        bit          e_v;
        bit          chk_id;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    function automatic vec_t mk(bit rst, bit rdy, bit rv, logic [63:0] rpc, bit mv,
                                bit e_req, logic [63:0] e_addr, bit e_v, bit chk_id,
                                logic [63:0] e_pc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.mv = mv;
        v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.chk_id = chk_id;
        v.e_pc = e_pc;
        v.e_instr = rst ? 32'h0 : memword(e_pc);
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } slot_t;

    slot_t       slot[$];
    bit          m_boot;
    bit          m_drain;
    logic [63:0] m_pc;
    logic [63:0] m_drain_addr;
    int          m_fetch, m_stall, m_flush;

    task automatic model_reset();
        slot.delete();
        m_boot = 1'b1; m_drain = 1'b0;
        m_pc = 64'h0; m_drain_addr = 64'h0;
        m_fetch = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic step(input bit rst, input bit rdy, input bit rv, input logic [63:0] rpc, input bit mv);
        bit          exp_req, exp_v, mx, dx;
        logic [63:0] exp_addr;
        if (rst) model_reset();
        exp_v    = (slot.size() != 0);
        exp_req  = !m_boot && (m_drain || !exp_v || rdy);
        exp_addr = m_drain ? m_drain_addr : m_pc;

        rst_n              = !rst;
        bus.id_ready       = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.imem_valid     = mv;
        bus.imem_rdata     = memword(exp_addr);
        #1;
        chk("imem_req", bus.imem_req, exp_req);
        chk("imem_addr", bus.imem_addr, exp_addr);
        chk("id_valid", bus.id_valid, exp_v);
        if (exp_v) begin
            chk("id_pc", bus.id_pc, slot[0].pc);
            chk("id_instr", bus.id_instr, slot[0].instr);
        end
        if (rst) begin
            chk("rst id_pc", bus.id_pc, 64'h0);
            chk("rst id_instr", bus.id_instr, 64'h0);
        end
`ifdef ARKI_FETCH_PERF_EN
        chk("perf_fetch", perf_fetch_cnt, m_fetch);
        chk("perf_stall", perf_stall_cnt, m_stall);
        chk("perf_flush", perf_flush_cnt, m_flush);
`endif
        if (!rst) begin
            mx = exp_req && mv;
            dx = exp_v && rdy;
            if (rv) begin
                m_flush++;
                slot.delete();
                m_drain      = exp_req && !mv;
                m_drain_addr = exp_addr;
                m_boot       = 1'b0;
                m_pc         = rpc & ~64'h3;
            end else begin
                if (dx) m_fetch++;
                if (exp_v && !rdy) m_stall++;
                if (m_boot) begin
                    m_boot = 1'b0;
                end else if (m_drain) begin
                    if (mx) m_drain = 1'b0;
                end else begin
                    if (dx) void'(slot.pop_front());
                    if (mx) begin
                        slot.push_back('{instr: memword(exp_addr), pc: m_pc});
                        m_pc = m_pc + 64'd4;
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[28];
        rst_n              = 1'b0;
        bus.id_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.imem_valid     = 1'b0;
        bus.imem_rdata     = 32'h0;

        //           rst rdy rv rpc      mv  req addr     v chk pc
        tbl[0]  = mk(1, 1, 0, 64'h0,   0,  0, 64'h0,   0, 1, 64'h0);
        tbl[1]  = mk(0, 1, 0, 64'h0,   1,  0, 64'h0,   0, 0, 64'h0);
        tbl[2]  = mk(0, 1, 0, 64'h0,   1,  1, 64'h0,   0, 0, 64'h0);
        tbl[3]  = mk(0, 0, 0, 64'h0,   1,  0, 64'h4,   1, 1, 64'h0);
        tbl[4]  = mk(0, 0, 0, 64'h0,   1,  0, 64'h4,   1, 1, 64'h0);
        tbl[5]  = mk(0, 0, 0, 64'h0,   1,  0, 64'h4,   1, 1, 64'h0);
        tbl[6]  = mk(0, 1, 0, 64'h0,   1,  1, 64'h4,   1, 1, 64'h0);
        tbl[7]  = mk(0, 1, 0, 64'h0,   1,  1, 64'h8,   1, 1, 64'h4);
        tbl[8]  = mk(0, 1, 1, 64'h5C,  1,  1, 64'hC,   1, 1, 64'h8);
        tbl[9]  = mk(0, 1, 0, 64'h0,   0,  1, 64'h5C,  0, 0, 64'h0);
        tbl[10] = mk(0, 1, 0, 64'h0,   1,  1, 64'h5C,  0, 0, 64'h0);
        tbl[11] = mk(0, 0, 0, 64'h0,   0,  0, 64'h60,  1, 1, 64'h5C);
        tbl[12] = mk(1, 1, 0, 64'h0,   0,  0, 64'h0,   0, 1, 64'h0);
        tbl[13] = mk(0, 1, 0, 64'h0,   0,  0, 64'h0,   0, 0, 64'h0);
        tbl[14] = mk(0, 1, 0, 64'h0,   1,  1, 64'h0,   0, 0, 64'h0);
        tbl[15] = mk(0, 1, 0, 64'h0,   1,  1, 64'h4,   1, 1, 64'h0);
        tbl[16] = mk(0, 1, 1, 64'h100, 0,  1, 64'h8,   1, 1, 64'h4);
        tbl[17] = mk(0, 1, 0, 64'h0,   0,  1, 64'h8,   0, 0, 64'h0);
        tbl[18] = mk(0, 1, 0, 64'h0,   1,  1, 64'h8,   0, 0, 64'h0);
        tbl[19] = mk(0, 1, 0, 64'h0,   0,  1, 64'h100, 0, 0, 64'h0);
        tbl[20] = mk(0, 1, 0, 64'h0,   1,  1, 64'h100, 0, 0, 64'h0);
        tbl[21] = mk(0, 0, 0, 64'h0,   0,  0, 64'h104, 1, 1, 64'h100);
        tbl[22] = mk(0, 1, 1, 64'h200, 0,  1, 64'h104, 1, 1, 64'h100);
        tbl[23] = mk(0, 1, 0, 64'h0,   0,  1, 64'h104, 0, 0, 64'h0);
        tbl[24] = mk(1, 1, 0, 64'h0,   0,  0, 64'h0,   0, 1, 64'h0);
        tbl[25] = mk(0, 1, 1, 64'h103, 0,  0, 64'h0,   0, 0, 64'h0);
        tbl[26] = mk(0, 1, 0, 64'h0,   1,  1, 64'h100, 0, 0, 64'h0);
        tbl[27] = mk(0, 1, 0, 64'h0,   0,  1, 64'h104, 1, 1, 64'h100);

        @(negedge clk);
        for (int i = 0; i < 28; i++) begin
            rst_n              = !tbl[i].rst;
            bus.id_ready       = tbl[i].rdy;
            bus.redirect_valid = tbl[i].rv;
            bus.redirect_pc    = tbl[i].rpc;
            bus.imem_valid     = tbl[i].mv;
            bus.imem_rdata     = memword(tbl[i].e_addr);
            #1;
            chk($sformatf("row%0d imem_req", i), bus.imem_req, tbl[i].e_req);
            chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d id_valid", i), bus.id_valid, tbl[i].e_v);
            if (tbl[i].chk_id) begin
                chk($sformatf("row%0d id_pc", i), bus.id_pc, tbl[i].e_pc);
                chk($sformatf("row%0d id_instr", i), bus.id_instr, tbl[i].e_instr);
            end
            $display("vec %0d: req=%0b addr=%h id_valid=%0b id_pc=%h id_instr=%h",
                     i, bus.imem_req, bus.imem_addr, bus.id_valid, bus.id_pc, bus.id_instr);
            @(posedge clk);
            @(negedge clk);
        end

        // Streaming with two redirects: 10 decode transfers, 2 flushes, 1 stall cycle.
        step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
        for (int c = 0; c <= 16; c++) begin
            step(1'b0, (c != 16), (c == 6) || (c == 11), 64'h40 * c, 1'b1);
        end
        $display("perf sequence: model fetch=%0d flush=%0d stall=%0d", m_fetch, m_flush, m_stall);
`ifdef ARKI_FETCH_PERF_EN
        chk("seq perf_fetch", perf_fetch_cnt, 64'd10);
        chk("seq perf_flush", perf_flush_cnt, 64'd2);
        chk("seq perf_stall", perf_stall_cnt, 64'd1);
`endif

        // Random traffic checked every cycle against the queue model.
        step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        for (int n = 0; n < 3000; n++) begin
            bit          r_rst, r_rdy, r_rv, r_mv;
            logic [63:0] r_pc;
            r_rst = ($urandom_range(0, 299) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rv  = ($urandom_range(0, 15) == 0);
            r_mv  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 7) == 0)
                r_pc = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
            else
                r_pc = {$urandom, $urandom};
            step(r_rst, r_rdy, r_rv, r_pc, r_mv);
            if (n % 500 == 0)
                $display("random step %0d: checks=%0d pc=%h", n, n_checks, m_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
